// File: rtl/lane_rr_fifo_scheduler.sv
// Round-robin scheduler that drains NUM_LANES native FIFOs onto one AXI-Stream
// output, tagging each word with its lane on tdest and bounding each grant to MAX_BURST words.
module lane_rr_fifo_scheduler #(
    parameter int DATA_WIDTH = 256,
    parameter int NUM_LANES  = 4,
    parameter int MAX_BURST  = 16,
    localparam int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_LANES-1:0]            lane_enable,
    input  logic [NUM_LANES-1:0]            empty,
    output logic [NUM_LANES-1:0]            rd_en,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] dout,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [LW-1:0]                   m_axis_tdest,
    output logic                            m_axis_tlast,
    output logic                            busy
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, SEND} state_t;

    state_t                state, state_next;
    logic [LW-1:0]         grant, grant_next;
    logic [LW-1:0]         last_grant, last_grant_next;
    logic [BW-1:0]         burst_cnt, burst_cnt_next;
    logic [BW-1:0]         burst_inc;
    logic                  tvalid_next, tlast_next, last_now;
    logic [DATA_WIDTH-1:0] tdata_next, lane_word;
    logic [LW-1:0]         tdest_next;
    logic [NUM_LANES-1:0]  req;
    logic [LW-1:0]         winner, cand;
    logic                  found;
    int unsigned           lg;

    assign req = lane_enable & ~empty;

    // Scan starts one past the previous winner so every lane gets a fair turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        lg     = {{(32-LW){1'b0}}, last_grant};
        for (int unsigned k = 1; k <= NUM_LANES; k++) begin
            cand = LW'((lg + k) % NUM_LANES);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        lane_word = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (LW'(i) == grant) lane_word = dout[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign burst_inc = burst_cnt + BW'(1);
    assign last_now  = (burst_inc == BW'(MAX_BURST)) | empty[grant] | ~lane_enable[grant];

    always_comb begin
        rd_en = '0;
        if (state == READ) rd_en[grant] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        burst_cnt_next  = burst_cnt;
        tvalid_next     = m_axis_tvalid;
        tdata_next      = m_axis_tdata;
        tdest_next      = m_axis_tdest;
        tlast_next      = m_axis_tlast;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next     = winner;
                    burst_cnt_next = '0;
                    state_next     = READ;
                end
            end
            READ: state_next = CAPTURE;
            CAPTURE: begin
                tdata_next     = lane_word;
                tdest_next     = grant;
                tvalid_next    = 1'b1;
                burst_cnt_next = burst_inc;
                tlast_next     = last_now;
                state_next     = SEND;
            end
            SEND: begin
                if (m_axis_tvalid && m_axis_tready) begin
                    tvalid_next = 1'b0;
                    if (m_axis_tlast) begin
                        last_grant_next = grant;
                        state_next      = IDLE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= LW'(NUM_LANES - 1);
            burst_cnt     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tdest  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            last_grant    <= last_grant_next;
            burst_cnt     <= burst_cnt_next;
            m_axis_tvalid <= tvalid_next;
            m_axis_tdata  <= tdata_next;
            m_axis_tdest  <= tdest_next;
            m_axis_tlast  <= tlast_next;
        end
    end

endmodule
